// File: rtl/result_collector_if.sv
// Sample-in / result-out handshake bundle for result_collector.
interface result_collector_if;
  localparam int unsigned DW = 13;

  logic          in_valid;
  logic [DW-1:0] y_in;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;

  // Producer/consumer side (drives samples, accepts results)
  modport master (
    output in_valid,
    output y_in,
    output out_ready,
    input  out_valid,
    input  out_data
  );

  // Collector side
  modport slave (
    input  in_valid,
    input  y_in,
    input  out_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/result_collector.sv
// Collects a batch of sign-magnitude results, converts them to two's complement
// and buffers them in a first-word-fall-through FIFO with drop/overflow
// accounting and a running checksum of handed-off values.
module result_collector #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned N_RESULTS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  result_collector_if.slave   bus,
  output logic [7:0]          in_count,
  output logic [7:0]          drop_count,
  output logic                overflow,
  output logic [20:0]         checksum,
  output logic                batch_done
);

  localparam int unsigned DW = 13;
  localparam int unsigned CW = 21;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned OW = AW + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [OW-1:0] occ_q, occ_d;
  logic          out_valid_q, out_valid_d;
  logic [DW-1:0] out_data_q, out_data_d;
  logic [7:0]    in_count_q, in_count_d;
  logic [7:0]    drop_q, drop_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] csum_q, csum_d;
  logic          done_q, done_d;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] conv;
  logic          full, pop, accept, push, drop;

  // Next-state, FIFO bookkeeping and counters
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    occ_d      = occ_q;
    in_count_d = in_count_q;
    drop_d     = drop_q;
    ovf_d      = ovf_q;
    csum_d     = csum_q;
    out_data_d = '0;

    // Negative zero folds to zero because ~0 + 1 wraps to 0
    conv = bus.y_in[12] ? (~{1'b0, bus.y_in[11:0]} + DW'(1)) : {1'b0, bus.y_in[11:0]};

    full   = (occ_q == OW'(DEPTH));
    pop    = out_valid_q & bus.out_ready;
    accept = (state_q == RUN) & bus.in_valid;
    push   = accept & (~full | pop);
    drop   = accept & full & ~pop;

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      csum_d   = csum_q + {{(CW-DW){out_data_q[DW-1]}}, out_data_q};
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RUN;
          in_count_d = '0;
          drop_d     = '0;
          ovf_d      = 1'b0;
          csum_d     = '0;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          in_count_d = in_count_q + 8'd1;
          if (drop) begin
            drop_d = (drop_q == 8'hFF) ? drop_q : drop_q + 8'd1;
            ovf_d  = 1'b1;
          end
          if (in_count_q + 8'd1 == 8'(N_RESULTS)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (occ_d == '0) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered FIFO head: bypass the incoming sample when it lands at the read slot
    if (occ_d != '0) begin
      if (push && (rd_ptr_d == wr_ptr_q)) begin
        out_data_d = conv;
      end else begin
        out_data_d = mem[rd_ptr_d];
      end
    end
    out_valid_d = (occ_d != '0);
    done_d      = (state_d == DONE);
  end

  // State and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      occ_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      in_count_q  <= '0;
      drop_q      <= '0;
      ovf_q       <= 1'b0;
      csum_q      <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      occ_q       <= occ_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      in_count_q  <= in_count_d;
      drop_q      <= drop_d;
      ovf_q       <= ovf_d;
      csum_q      <= csum_d;
      done_q      <= done_d;
    end
  end

  // FIFO storage; push is only possible in RUN, so reset needs no guard here
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= conv;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign in_count      = in_count_q;
  assign drop_count    = drop_q;
  assign overflow      = ovf_q;
  assign checksum      = csum_q;
  assign batch_done    = done_q;

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: a N_RESULTS=16 instance for the main
// scenarios and a N_RESULTS=4 instance for the short-batch end case.
module tb_result_collector;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned NA    = 16;
  localparam int unsigned NB    = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start_a = 1'b0;
  logic start_b = 1'b0;

  logic [7:0]  ic_a, dc_a, ic_b, dc_b;
  logic        of_a, bd_a, of_b, bd_b;
  logic [20:0] cs_a, cs_b;

  result_collector_if ifa();
  result_collector_if ifb();

  always #5 clk = ~clk;

  result_collector #(.DEPTH(DEPTH), .N_RESULTS(NA)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .bus(ifa),
    .in_count(ic_a), .drop_count(dc_a), .overflow(of_a),
    .checksum(cs_a), .batch_done(bd_a)
  );

  result_collector #(.DEPTH(DEPTH), .N_RESULTS(NB)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .bus(ifb),
    .in_count(ic_b), .drop_count(dc_b), .overflow(of_b),
    .checksum(cs_b), .batch_done(bd_b)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 idle, 1 run, 2 drain, 3 done
  int          m_state [2];
  int          m_cnt   [2];
  int          m_drop  [2];
  logic [20:0] m_csum  [2];
  logic [12:0] qa[$];
  logic [12:0] qb[$];

  function automatic logic [12:0] to_twos(input logic [12:0] y);
    int v;
    v = int'(y[11:0]);
    if (y[12]) v = -v;
    return 13'(v);
  endfunction

  function automatic int sext13(input logic [12:0] v);
    return v[12] ? int'(v) - 8192 : int'(v);
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      m_state[s] = 0; m_cnt[s] = 0; m_drop[s] = 0; m_csum[s] = '0;
    end
    qa.delete();
    qb.delete();
  endfunction

  // One clock of stimulus on instance sel; scoreboard pops are checked against out_data
  task automatic drive_cycle(input int sel, input logic st, input logic iv,
                             input logic [12:0] y, input logic rdy);
    logic [12:0] head, od, exp_head;
    logic        ov;
    int          sz;
    int          nres;
    if (sel == 0) begin
      start_a = st; ifa.in_valid = iv; ifa.y_in = y; ifa.out_ready = rdy;
      od = ifa.out_data; sz = qa.size(); nres = NA;
    end else begin
      start_b = st; ifb.in_valid = iv; ifb.y_in = y; ifb.out_ready = rdy;
      od = ifb.out_data; sz = qb.size(); nres = NB;
    end
    if (rdy && sz > 0) begin
      if (sel == 0) head = qa.pop_front(); else head = qb.pop_front();
      sz--;
      n_vec++;
      if (od !== head) begin
        n_err++;
        $display("FAIL pop_data dut%0d: got %h expected %h", sel, od, head);
      end
      m_csum[sel] = m_csum[sel] + 21'(sext13(head));
    end
    case (m_state[sel])
      0, 3: begin
        if (st) begin
          m_state[sel] = 1; m_cnt[sel] = 0; m_drop[sel] = 0; m_csum[sel] = '0;
        end
      end
      1: begin
        if (iv) begin
          m_cnt[sel]++;
          if (sz < int'(DEPTH)) begin
            if (sel == 0) qa.push_back(to_twos(y)); else qb.push_back(to_twos(y));
            sz++;
          end else if (m_drop[sel] < 255) begin
            m_drop[sel]++;
          end
          if (m_cnt[sel] == nres) m_state[sel] = 2;
        end
      end
      2: begin
        if (sz == 0) m_state[sel] = 3;
      end
      default: ;
    endcase
    @(posedge clk);
    @(negedge clk);
    if (sel == 0) begin
      ov = ifa.out_valid; od = ifa.out_data;
      exp_head = (qa.size() > 0) ? qa[0] : 13'd0;
    end else begin
      ov = ifb.out_valid; od = ifb.out_data;
      exp_head = (qb.size() > 0) ? qb[0] : 13'd0;
    end
    n_vec++;
    if (ov !== (sz != 0)) begin
      n_err++;
      $display("FAIL out_valid dut%0d: got %b expected %b", sel, ov, (sz != 0));
    end
    if (sz != 0) begin
      n_vec++;
      if (od !== exp_head) begin
        n_err++;
        $display("FAIL head_data dut%0d: got %h expected %h", sel, od, exp_head);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({ifa.out_valid, ifa.out_data, ic_a, dc_a, of_a, cs_a, bd_a} !== 53'd0) begin
      n_err++;
      $display("FAIL reset_a: got %h expected 0", {ifa.out_valid, ifa.out_data, ic_a, dc_a, of_a, cs_a, bd_a});
    end
    n_vec++;
    if ({ifb.out_valid, ifb.out_data, ic_b, dc_b, of_b, cs_b, bd_b} !== 53'd0) begin
      n_err++;
      $display("FAIL reset_b: got %h expected 0", {ifb.out_valid, ifb.out_data, ic_b, dc_b, of_b, cs_b, bd_b});
    end
    rst = 1'b1;
    model_reset();
    drive_cycle(0, 1'b0, 1'b1, 13'h0555, 1'b1);
    drive_cycle(0, 1'b0, 1'b0, 13'h0000, 1'b1);
    n_vec++;
    if (ic_a !== 8'd0) begin
      n_err++;
      $display("FAIL idle_ignores_input: in_count %0d expected 0", ic_a);
    end
  endtask

  task automatic test_basic();
    drive_cycle(0, 1'b1, 1'b0, 13'h0000, 1'b1);
    drive_cycle(0, 1'b0, 1'b1, 13'h0800, 1'b1);
    n_vec++;
    if (ifa.out_data !== 13'h0800) begin
      n_err++;
      $display("FAIL basic_first: got %h expected 0800", ifa.out_data);
    end
    drive_cycle(0, 1'b0, 1'b1, 13'h1800, 1'b1);
    n_vec++;
    if (ifa.out_data !== 13'h1800) begin
      n_err++;
      $display("FAIL basic_second: got %h expected 1800", ifa.out_data);
    end
    drive_cycle(0, 1'b0, 1'b1, 13'h1000, 1'b1);
    n_vec++;
    if (ifa.out_data !== 13'h0000) begin
      n_err++;
      $display("FAIL basic_negzero: got %h expected 0000", ifa.out_data);
    end
    drive_cycle(0, 1'b0, 1'b0, 13'h0000, 1'b1);
    n_vec++;
    if (cs_a !== 21'd0 || ic_a !== 8'd3) begin
      n_err++;
      $display("FAIL basic_sum_count: got cs %h ic %0d expected cs 0 ic 3", cs_a, ic_a);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) drive_cycle(0, 1'b0, 1'b1, 13'(i + 1), 1'b0);
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({ifa.out_valid, ifa.out_data, ic_a, dc_a, of_a, cs_a, bd_a} !== 53'd0) begin
      n_err++;
      $display("FAIL async_reset: got %h expected 0", {ifa.out_valid, ifa.out_data, ic_a, dc_a, of_a, cs_a, bd_a});
    end
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) drive_cycle(0, 1'b0, 1'b1, 13'h0123, 1'b1);
    n_vec++;
    if (ic_a !== 8'd0 || ifa.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_idle: got ic %0d ov %b expected 0 0", ic_a, ifa.out_valid);
    end
  endtask

  task automatic test_overflow();
    drive_cycle(0, 1'b1, 1'b0, 13'h0000, 1'b0);
    for (int i = 0; i < 10; i++) drive_cycle(0, 1'b0, 1'b1, 13'((i % 2) * 4096 + 100 * (i + 1)), 1'b0);
    n_vec++;
    if (ic_a !== 8'd10 || dc_a !== 8'd2 || of_a !== 1'b1 || ifa.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL overflow_status: got ic %0d dc %0d of %b ov %b expected 10 2 1 1", ic_a, dc_a, of_a, ifa.out_valid);
    end
    repeat (3) drive_cycle(0, 1'b0, 1'b0, 13'h0000, 1'b0);
    n_vec++;
    if (ifa.out_data !== 13'h0064) begin
      n_err++;
      $display("FAIL overflow_head_held: got %h expected 0064", ifa.out_data);
    end
  endtask

  task automatic test_full_simul();
    drive_cycle(0, 1'b0, 1'b1, 13'h1FFF, 1'b1);
    drive_cycle(0, 1'b0, 1'b1, 13'h0FFF, 1'b1);
    n_vec++;
    if (dc_a !== 8'd2 || ic_a !== 8'd12 || ifa.out_data !== 13'h012C) begin
      n_err++;
      $display("FAIL full_simul: got dc %0d ic %0d head %h expected 2 12 012C", dc_a, ic_a, ifa.out_data);
    end
  endtask

  task automatic test_drain();
    int guard;
    for (int i = 0; i < 4; i++) drive_cycle(0, 1'b0, 1'b1, 13'(4096 + 7 * i), 1'b1);
    drive_cycle(0, 1'b0, 1'b1, 13'h0123, 1'b1);
    n_vec++;
    if (ic_a !== 8'd16) begin
      n_err++;
      $display("FAIL drain_ignores_input: in_count %0d expected 16", ic_a);
    end
    guard = 0;
    while (m_state[0] != 3 && guard < 20) begin
      drive_cycle(0, 1'b0, 1'b0, 13'h0000, 1'b1);
      guard++;
    end
    n_vec++;
    if (bd_a !== 1'b1 || cs_a !== m_csum[0] || dc_a !== 8'd2 || of_a !== 1'b1) begin
      n_err++;
      $display("FAIL drain_done: got bd %b cs %h dc %0d of %b expected 1 %h 2 1", bd_a, cs_a, dc_a, of_a, m_csum[0]);
    end
  endtask

  task automatic test_restart();
    drive_cycle(0, 1'b1, 1'b0, 13'h0000, 1'b0);
    n_vec++;
    if ({ic_a, dc_a, of_a, cs_a, bd_a} !== 39'd0) begin
      n_err++;
      $display("FAIL restart_clear: got %h expected 0", {ic_a, dc_a, of_a, cs_a, bd_a});
    end
    drive_cycle(0, 1'b0, 1'b1, 13'h0005, 1'b1);
    drive_cycle(0, 1'b1, 1'b1, 13'h0006, 1'b1);
    drive_cycle(0, 1'b0, 1'b0, 13'h0000, 1'b1);
    n_vec++;
    if (ic_a !== 8'd2 || cs_a !== 21'd11) begin
      n_err++;
      $display("FAIL start_in_run: got ic %0d cs %0d expected 2 11", ic_a, cs_a);
    end
  endtask

  task automatic test_batch_end();
    int guard;
    drive_cycle(1, 1'b1, 1'b0, 13'h0000, 1'b0);
    for (int i = 0; i < 4; i++) drive_cycle(1, 1'b0, 1'b1, 13'h0001, 1'b0);
    drive_cycle(1, 1'b0, 1'b1, 13'h0002, 1'b0);
    n_vec++;
    if (ic_b !== 8'd4 || bd_b !== 1'b0 || ifb.out_valid !== 1'b1) begin
      n_err++;
      $display("FAIL batch_end_drain: got ic %0d bd %b ov %b expected 4 0 1", ic_b, bd_b, ifb.out_valid);
    end
    guard = 0;
    while (m_state[1] != 3 && guard < 20) begin
      drive_cycle(1, 1'b0, 1'b0, 13'h0000, 1'b1);
      guard++;
    end
    n_vec++;
    if (bd_b !== 1'b1 || cs_b !== 21'd4 || guard !== 4) begin
      n_err++;
      $display("FAIL batch_end_done: got bd %b cs %0d pops %0d expected 1 4 4", bd_b, cs_b, guard);
    end
  endtask

  initial begin
    ifa.in_valid = 1'b0; ifa.y_in = '0; ifa.out_ready = 1'b0;
    ifb.in_valid = 1'b0; ifb.y_in = '0; ifb.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_async_reset();
    test_overflow();
    test_full_simul();
    test_drain();
    test_restart();
    test_batch_end();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
